wb_stage: RTL and testbench

//   Write-back stage of the RISC-V integer pipeline: MEM/WB pipeline register, result select,

---
 rtl/rv_pkg.sv | 28 ++
 rtl/wb_stage_if.sv | 27 ++
 rtl/load_extend.sv | 40 ++++
 rtl/wb_stage.sv | 89 ++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V pipeline encodings and types
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] rd;
        logic [1:0] result_src;
        logic [2:0] funct3;
        logic [1:0] byte_off;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB instruction bus with pipeline control
interface wb_stage_if #(parameter int XLEN = rv_pkg::XLEN) ();
    logic            stall;
    logic            flush;
    logic            in_valid;
    logic            in_reg_write;
    logic [4:0]      in_rd;
    logic [1:0]      in_result_src;
    logic [XLEN-1:0] in_alu_result;
    logic [31:0]     in_load_data;
    logic [2:0]      in_funct3;
    logic [1:0]      in_byte_off;
    logic [XLEN-1:0] in_pc_plus4;
    logic [XLEN-1:0] in_imm;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_rd, in_result_src,
               in_alu_result, in_load_data, in_funct3, in_byte_off,
               in_pc_plus4, in_imm
    );

    modport slave (
        input stall, flush, in_valid, in_reg_write, in_rd, in_result_src,
              in_alu_result, in_load_data, in_funct3, in_byte_off,
              in_pc_plus4, in_imm
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of load data
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [31:0]     data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = data[7:0];
        case (byte_off)
            2'd0: lane_b = data[7:0];
            2'd1: lane_b = data[15:8];
            2'd2: lane_b = data[23:16];
            2'd3: lane_b = data[31:24];
            default: lane_b = data[7:0];
        endcase
        // halfword lane only looks at the upper offset bit
        lane_h = byte_off[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        result = {{(XLEN-32){data[31]}}, data};
        case (funct3)
            F3_LB:   result = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LH:   result = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, lane_b};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, lane_h};
            default: result = {{(XLEN-32){data[31]}}, data};
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: MEM/WB register, result select, x0 suppression, retire count
module wb_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    wb_stage_if.slave        mem,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD3,
    output logic             WE3,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    wb_ctrl_t        wb_ctrl;
    logic [XLEN-1:0] wb_alu;
    logic [31:0]     wb_load;
    logic [XLEN-1:0] wb_pc4;
    logic [XLEN-1:0] wb_imm;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;
    logic            retire;

    // flush wins over stall; a flushed slot keeps stale fields but is a bubble
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wb_ctrl <= '0;
            wb_alu  <= '0;
            wb_load <= '0;
            wb_pc4  <= '0;
            wb_imm  <= '0;
        end else if (mem.flush) begin
            wb_ctrl.valid <= 1'b0;
        end else if (!mem.stall) begin
            wb_ctrl.valid      <= mem.in_valid;
            wb_ctrl.reg_write  <= mem.in_reg_write;
            wb_ctrl.rd         <= mem.in_rd;
            wb_ctrl.result_src <= mem.in_result_src;
            wb_ctrl.funct3     <= mem.in_funct3;
            wb_ctrl.byte_off   <= mem.in_byte_off;
            wb_alu             <= mem.in_alu_result;
            wb_load            <= mem.in_load_data;
            wb_pc4             <= mem.in_pc_plus4;
            wb_imm             <= mem.in_imm;
        end
    end

    // an instruction retires when it leaves WB, so a stalled one counts once
    assign retire = wb_ctrl.valid & (~mem.stall | mem.flush);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data     (wb_load),
        .funct3   (wb_ctrl.funct3),
        .byte_off (wb_ctrl.byte_off),
        .result   (load_val)
    );

    always_comb begin
        result = wb_alu;
        case (wb_ctrl.result_src)
            RES_ALU:  result = wb_alu;
            RES_LOAD: result = load_val;
            RES_PC4:  result = wb_pc4;
            RES_IMM:  result = wb_imm;
            default:  result = wb_alu;
        endcase
    end

    assign WE3       = wb_ctrl.valid & wb_ctrl.reg_write & (wb_ctrl.rd != 5'd0);
    assign A3        = WE3 ? wb_ctrl.rd : 5'd0;
    assign WD3       = WE3 ? result : '0;
    assign fwd_valid = WE3;
    assign fwd_rd    = A3;
    assign fwd_data  = WD3;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    logic        CLK;
    logic        RST;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    wb_stage_if #(.XLEN(32)) mif ();

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mem       (mif),
        .A3        (A3),
        .WD3       (WD3),
        .WE3       (WE3),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .instret   (instret)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[13];
    int          total = 0;
    int          bad = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_cnt = 64'd0;

    function automatic vec_t mk(logic valid, logic rw, logic [4:0] rd, logic [1:0] src,
                                logic [31:0] alu, logic [31:0] ld, logic [2:0] f3,
                                logic [1:0] off, logic [31:0] pc4, logic [31:0] imm,
                                logic we, logic [4:0] a3, logic [31:0] wd);
        vec_t v;
        v.valid = valid; v.rw = rw; v.rd = rd; v.src = src; v.alu = alu; v.ld = ld;
        v.f3 = f3; v.off = off; v.pc4 = pc4; v.imm = imm;
        v.exp_we = we; v.exp_a3 = a3; v.exp_wd = wd;
        return v;
    endfunction

    function automatic exp_t ex(logic we, logic [4:0] a3, logic [31:0] wd);
        exp_t e;
        e.we = we; e.a3 = a3; e.wd = wd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        mif.in_valid      = v.valid;
        mif.in_reg_write  = v.rw;
        mif.in_rd         = v.rd;
        mif.in_result_src = v.src;
        mif.in_alu_result = v.alu;
        mif.in_load_data  = v.ld;
        mif.in_funct3     = v.f3;
        mif.in_byte_off   = v.off;
        mif.in_pc_plus4   = v.pc4;
        mif.in_imm        = v.imm;
    endtask

    // one clock: expected result queued at drive time, popped after the edge
    task automatic cyc(input string name, input logic st, input logic fl, input exp_t e);
        exp_t r;
        mif.stall = st;
        mif.flush = fl;
        sb.push_back(e);
        @(posedge CLK);
        if (m_valid && (!st || fl)) m_cnt = m_cnt + 64'd1;
        if (fl) m_valid = 1'b0;
        else if (!st) m_valid = mif.in_valid;
        @(negedge CLK);
        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            r = sb.pop_front();
            chk({name, ".WE3"}, {63'd0, WE3}, {63'd0, r.we});
            chk({name, ".A3"}, {59'd0, A3}, {59'd0, r.a3});
            chk({name, ".WD3"}, {32'd0, WD3}, {32'd0, r.wd});
            chk({name, ".fwd"}, {26'd0, fwd_valid, fwd_rd, fwd_data},
                {26'd0, r.we, r.a3, r.wd});
            chk({name, ".instret"}, instret, m_cnt);
        end
    endtask

    initial begin
        vt[0]  = mk(1,1, 5,2'b00,32'h12345678,32'h0,       3'b000,2'd0,32'h0,  32'h0,        1, 5,32'h12345678);
        vt[1]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b000,2'd1,32'h0,  32'h0,        1,10,32'h0000007F);
        vt[2]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b000,2'd2,32'h0,  32'h0,        1,10,32'hFFFFFFFF);
        vt[3]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b100,2'd3,32'h0,  32'h0,        1,10,32'h00000080);
        vt[4]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b001,2'd2,32'h0,  32'h0,        1,10,32'hFFFF80FF);
        vt[5]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b101,2'd0,32'h0,  32'h0,        1,10,32'h00007F01);
        vt[6]  = mk(1,1,10,2'b01,32'h0,       32'h80FF7F01,3'b010,2'd0,32'h0,  32'h0,        1,10,32'h80FF7F01);
        vt[7]  = mk(1,1,11,2'b01,32'h0,       32'h80FF7F01,3'b011,2'd1,32'h0,  32'h0,        1,11,32'h80FF7F01);
        vt[8]  = mk(1,1, 0,2'b00,32'hDEADBEEF,32'h0,       3'b000,2'd0,32'h0,  32'h0,        0, 0,32'h0);
        vt[9]  = mk(1,0, 6,2'b00,32'h00000001,32'h0,       3'b000,2'd0,32'h0,  32'h0,        0, 0,32'h0);
        vt[10] = mk(0,1, 4,2'b00,32'h00000002,32'h0,       3'b000,2'd0,32'h0,  32'h0,        0, 0,32'h0);
        vt[11] = mk(1,1,31,2'b11,32'h0,       32'h0,       3'b000,2'd0,32'h0,  32'hABCDE000, 1,31,32'hABCDE000);
        vt[12] = mk(1,1, 2,2'b10,32'h0000FFFF,32'h0,       3'b000,2'd0,32'h200,32'h0,        1, 2,32'h00000200);

        RST = 1'b0;
        mif.stall = 1'b0;
        mif.flush = 1'b0;
        drive(mk(1,1,3,2'b00,32'h55,0,0,0,0,0, 0,0,0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset.WE3", {63'd0, WE3}, 64'd0);
        chk("reset.WD3", {32'd0, WD3}, 64'd0);
        chk("reset.instret", instret, 64'd0);
        mif.in_valid = 1'b0;
        RST = 1'b1;
        cyc("post_reset", 0, 0, ex(0, 0, 0));

        for (int i = 0; i < 13; i++) begin
            drive(vt[i]);
            cyc($sformatf("vec%0d", i), 0, 0, ex(vt[i].exp_we, vt[i].exp_a3, vt[i].exp_wd));
        end

        drive(mk(1,1,7,2'b00,32'h7777,0,0,0,0,0, 0,0,0));
        cyc("stall.load", 0, 0, ex(1, 7, 32'h7777));
        drive(mk(1,1,12,2'b00,32'h1,0,0,0,0,0, 0,0,0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("stall.hold%0d", i), 1, 0, ex(1, 7, 32'h7777));
        chk("stall.not_counted", instret, m_cnt);
        drive(mk(0,0,0,2'b00,0,0,0,0,0,0, 0,0,0));
        cyc("stall.release", 0, 0, ex(0, 0, 0));

        drive(mk(1,1,9,2'b00,32'h99,0,0,0,0,0, 0,0,0));
        cyc("flush.load", 0, 0, ex(1, 9, 32'h99));
        drive(mk(1,1,13,2'b00,32'h13,0,0,0,0,0, 0,0,0));
        cyc("flush.stall", 1, 1, ex(0, 0, 0));
        drive(mk(1,1,1,2'b10,32'h0,0,0,0,32'h104,0, 0,0,0));
        cyc("jal", 0, 0, ex(1, 1, 32'h104));

        drive(mk(1,1,8,2'b00,32'h88,0,0,0,0,0, 0,0,0));
        cyc("rst_stall.load", 0, 0, ex(1, 8, 32'h88));
        mif.stall = 1'b1;
        #2 RST = 1'b0;
        #1;
        chk("rst_stall.WE3", {63'd0, WE3}, 64'd0);
        chk("rst_stall.A3", {59'd0, A3}, 64'd0);
        chk("rst_stall.WD3", {32'd0, WD3}, 64'd0);
        chk("rst_stall.instret", instret, 64'd0);
        m_cnt = 64'd0;
        m_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        drive(mk(0,0,0,2'b00,0,0,0,0,0,0, 0,0,0));
        cyc("rst_stall.after", 0, 0, ex(0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
